instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Parametrised instruction fetch stage with a DEPTH-entry prefetch queue. It replaces the single-slot fetch FSM. It runs ahead of decode: it issues sequential word fetches over a request/grant/response memory port and buffers the returned instructions. Buffered instructions are delivered through a valid/ready handshake. Redirects flush the queue, and any stale in-flight response is dropped. It sits between the I-cache and the decode stage.

## Interface
- XLEN, 32, address/instruction width; instruction word is 4 bytes.
- DEPTH, 4, prefetch queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_redirect  in  1  load new PC; flush queue.
- i_redirect_pc  in  XLEN  redirect target.
- i_halt  in  1  level; while high, no new memory requests are issued.
- o_mem_req  out  1  fetch request.
- o_mem_addr  out  XLEN  fetch byte address.
- i_mem_gnt  in  1  request accepted when o_mem_req && i_mem_gnt.
- i_mem_rvalid  in  1  response valid; exactly one per grant, at least 1 cycle after grant.
- i_mem_rdata  in  XLEN  instruction word.
- o_valid  out  1  queue head valid.
- o_pc  out  XLEN  PC of head instruction.
- o_instruction  out  XLEN  head instruction.
- i_ready  in  1  decode accepts head when o_valid && i_ready.
- o_fault  out  1  misaligned redirect fault. Constant 0 unless IFQ_MISALIGN_TRAP_EN is defined.

## Operation
- Fetch PC register `fpc`, byte addressed; sequential increment is +4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
- At most one outstanding memory request.
- FSM states:
  - ISSUE: o_mem_req=1, o_mem_addr=fpc. On grant go to WAIT and set fpc += 4.
  - WAIT: wait for i_mem_rvalid, then go to ISSUE or STALL.
  - STALL: no request. Leave when the issue condition holds.
- Issue condition: i_halt==0 && (count + 1) <= DEPTH − 0 slots reserved, i.e. count < DEPTH. The slot for the outstanding response is reserved, so a response never finds the queue full.
- Queue: circular buffer, head/tail pointers $clog2(DEPTH) bits, count $clog2(DEPTH+1) bits.
  - o_valid = (count != 0).
  - o_pc/o_instruction come from the head entry.
  - Push on accepted response; pop on handshake; simultaneous push and pop leaves count unchanged.
- Stored PC is the address the request was issued with, not the current fpc.
- Redirect (highest priority over everything in the same cycle):
  - Flush the queue (count=0, head=tail).
  - A pop in the same cycle is discarded; decode must ignore it.
  - Set fpc = i_redirect_pc and go to ISSUE (or STALL if i_halt).
  - If a response is outstanding, or is granted this cycle, set `drop`. The next i_mem_rvalid is discarded and clears `drop`. No new request is issued while `drop` is set.
  - If a response arrives in the redirect cycle itself, it is discarded.
  - An ungranted ISSUE retargets: o_mem_addr changes next cycle. The memory port permits retraction of ungranted requests.
- Halt: requests stop from the cycle after i_halt rises. The outstanding response still completes and is pushed. Delivery to decode continues. Fetch resumes from fpc when i_halt falls.
- Reset values: o_mem_req=0, o_valid=0, count=0, drop=0, o_fault=0, fpc=RESET_PC, state=ISSUE. o_pc/o_instruction are don't-care while o_valid=0 but are reset to 0.
- Reset mid-fetch: all state cleared. The memory is reset by the same i_reset, so no stale response follows.

## Timing
- First request: o_mem_req=1 in the first cycle after i_reset deasserts.
- Grant at cycle t, response at t+k (k≥1): o_valid rises at t+k+1, and the next o_mem_req is asserted at t+k+1.
- Steady state with k=1 and continuous ready: one instruction every 2 cycles.
- Redirect at cycle r with no outstanding request: request to the new PC at r+1, and o_valid=0 at r+1.
- All outputs are registered; there is no combinational path from i_ready or i_redirect to the outputs.

## Configuration
- IFQ_MISALIGN_TRAP_EN defined:
  - A redirect with i_redirect_pc[1:0]!=0 flushes the queue, issues no request, sets o_fault=1 and enters STALL.
  - o_fault is sticky until the next aligned redirect or reset.
- Not defined: o_fault is tied 0 and i_redirect_pc[1:0] is forced to 00.

## Test plan
- Reset, memory grants immediately with k=1, i_ready=1 -> o_mem_addr sequence 0,4,8,…; o_valid pulses with o_pc 0,4,8 and o_instruction equal to the memory contents.
- i_ready=0, DEPTH=4 -> exactly 4 responses queued, o_mem_req stays 0. Raising i_ready drains PCs 0,4,8,12 in order, then fetching resumes at 16.
- Redirect to 0x100 while a request to 0x8 is in WAIT -> the 0x8 response is dropped, the next request is to 0x100, and the first o_pc is 0x100.
- fpc=0xFFFF_FFFC -> the following request address is 0x0000_0000.
- i_halt=1 during WAIT -> the response is still enqueued, no further o_mem_req; i_halt=0 -> request at the next sequential PC.
- With IFQ_MISALIGN_TRAP_EN, redirect to 0x102 -> o_fault=1, o_mem_req=0. Redirect to 0x200 -> o_fault=0 and a request to 0x200.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
//   Instruction fetch stage with a DEPTH-entry prefetch queue. It issues
//   sequential word fetches over a req/gnt/rvalid memory port and keeps at
//   most one request outstanding. Returned words are buffered with the PC
//   they were fetched from, and decode drains them through a valid/ready
//   handshake. A redirect flushes the queue. A response that is still in
//   flight when the redirect happens is dropped.
//
//   Optional feature macro: IFQ_MISALIGN_TRAP_EN
//     defined   : a redirect to a non-word-aligned target raises a sticky
//                 o_fault and stalls fetch until the next aligned redirect.
//     undefined : o_fault is tied low and i_redirect_pc[1:0] is ignored.
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_redirect, i_redirect_pc   load a new fetch PC and flush the queue
//   i_halt                      level; suppresses new memory requests
//   o_mem_req, o_mem_addr       fetch request and byte address
//   i_mem_gnt                   request accepted when o_mem_req && i_mem_gnt
//   i_mem_rvalid, i_mem_rdata   one response per grant
//   o_valid, o_pc, o_instruction  queue head presented to decode
//   i_ready                     decode accepts the head
//   o_fault                     misaligned redirect fault (sticky)
module instruction_fetch_queue #(
  parameter int unsigned         XLEN     = 32,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [XLEN-1:0]     RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_halt,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instruction,
  input  logic            i_ready,
  output logic            o_fault
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_STALL = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] ipc_q, ipc_d;     // address of the outstanding request
  logic            req_q, req_d;
  logic            drop_q, drop_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            fault_d;

  logic [XLEN-1:0] pc_mem_q  [DEPTH];
  logic [XLEN-1:0] ins_mem_q [DEPTH];

  logic            grant;
  logic            push;
  logic            pop;
  logic            issue_ok;
  logic            misaligned;
  logic [XLEN-1:0] redir_tgt;

`ifdef IFQ_MISALIGN_TRAP_EN
  logic fault_q;
  assign misaligned = (i_redirect_pc[1:0] != 2'b00);
  assign redir_tgt  = i_redirect_pc;
`else
  assign misaligned = 1'b0;
  assign redir_tgt  = i_redirect_pc & ~XLEN'(3);
`endif

  assign grant = req_q & i_mem_gnt;
  // A response landing in a redirect cycle belongs to the old stream.
  assign push  = (state_q == S_WAIT) & i_mem_rvalid & ~i_redirect;
  assign pop   = (count_q != '0) & i_ready & ~i_redirect;

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    ipc_d    = ipc_q;
    drop_d   = drop_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    issue_ok = 1'b0;
`ifdef IFQ_MISALIGN_TRAP_EN
    fault_d  = fault_q;
`else
    fault_d  = 1'b0;
`endif

    if (i_redirect) begin
      count_d = '0;
      head_d  = tail_q;
      fpc_d   = redir_tgt;
      // The in-flight response (old WAIT, already-dropping, or granted right
      // now) must be swallowed unless it is arriving in this very cycle.
      drop_d  = grant | (((state_q == S_WAIT) | drop_q) & ~i_mem_rvalid);
      if (misaligned) begin
        state_d = S_STALL;
        fault_d = 1'b1;
      end else begin
        fault_d = 1'b0;
        state_d = i_halt ? S_STALL : S_ISSUE;
      end
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (drop_q && i_mem_rvalid) drop_d = 1'b0;

      // Using the next-cycle occupancy reserves a slot for the response of
      // the request about to be issued.
      issue_ok = ~i_halt & (count_d < CW'(DEPTH)) & ~fault_d;

      unique case (state_q)
        S_ISSUE: begin
          if (grant) begin
            ipc_d   = fpc_q;
            fpc_d   = fpc_q + XLEN'(4);
            state_d = S_WAIT;
          end else if (!issue_ok) begin
            state_d = S_STALL;   // ungranted request is retracted
          end
        end
        S_WAIT: begin
          if (i_mem_rvalid) state_d = issue_ok ? S_ISSUE : S_STALL;
        end
        S_STALL: begin
          if (issue_ok) state_d = S_ISSUE;
        end
        default: state_d = S_STALL;
      endcase
    end

    req_d = (state_d == S_ISSUE) & ~drop_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_ISSUE;
      fpc_q   <= RESET_PC;
      ipc_q   <= '0;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      ipc_q   <= ipc_d;
      req_q   <= req_d;
      drop_q  <= drop_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[tail_q]  <= ipc_q;
      ins_mem_q[tail_q] <= i_mem_rdata;
    end
  end

`ifdef IFQ_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) fault_q <= 1'b0;
    else         fault_q <= fault_d;
  end
  assign o_fault = fault_q;
`else
  assign o_fault = 1'b0;
`endif

  assign o_mem_req     = req_q;
  assign o_mem_addr    = fpc_q;
  assign o_valid       = (count_q != '0);
  assign o_pc          = pc_mem_q[head_q];
  assign o_instruction = ins_mem_q[head_q];

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Testbench for instruction_fetch_queue: directed stimulus, a memory
// responder with programmable latency, and a scoreboard monitor that checks
// every instruction accepted by decode against the queued expectations.
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_halt;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic        i_ready;
  logic        o_fault;

  always #5 clk = ~clk;

  instruction_fetch_queue #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_halt        (i_halt),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_gnt     (i_mem_gnt),
    .i_mem_rvalid  (i_mem_rvalid),
    .i_mem_rdata   (i_mem_rdata),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_instruction (o_instruction),
    .i_ready       (i_ready),
    .o_fault       (o_fault)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned mem_lat  = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5EED;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_insn(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = mem_word(pc);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int unsigned max_cycles);
    int unsigned n = 0;
    while (!o_mem_req && n < max_cycles) begin
      tick();
      n++;
    end
    check("req_seen", {31'b0, o_mem_req}, 32'd1);
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while ((sb.size() != 0 || o_valid) && n < 60) begin
      tick();
      n++;
    end
    check("drained", sb.size(), 32'd0);
  endtask

  // Memory responder: grants immediately, responds mem_lat cycles later.
  initial begin
    bit          pend = 1'b0;
    int unsigned cnt  = 0;
    logic [31:0] pa   = '0;
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    forever begin
      tick();
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      if (i_reset) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt <= 1) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = mem_word(pa);
          pend         = 1'b0;
        end else begin
          cnt--;
        end
      end else if (o_mem_req) begin
        i_mem_gnt = 1'b1;
        pend      = 1'b1;
        cnt       = mem_lat;
        pa        = o_mem_addr;
      end
    end
  end

  // Scoreboard monitor: every handshake with decode pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!i_reset && o_valid && i_ready && !i_redirect) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_insn: got pc %h expected none", o_pc);
        end else begin
          e = sb.pop_front();
          check("insn_pc", o_pc, e.pc);
          check("insn_data", o_instruction, e.ins);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    i_reset       = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_halt        = 1'b0;
    i_ready       = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_req",   {31'b0, o_mem_req}, 32'd0);
    check("rst_valid", {31'b0, o_valid},   32'd0);
    check("rst_fault", {31'b0, o_fault},   32'd0);
    check("rst_pc",    o_pc,          32'h0);
    check("rst_insn",  o_instruction, 32'h0);

    // Sequential fetch 0,4,8 with ready high; halt raised during the 8 request
    expect_insn(32'h0);
    expect_insn(32'h4);
    expect_insn(32'h8);
    i_reset = 1'b0;
    wait_req(3);
    check("addr0", o_mem_addr, 32'h0);
    tick();
    wait_req(6);
    check("addr4", o_mem_addr, 32'h4);
    tick();
    wait_req(6);
    check("addr8", o_mem_addr, 32'h8);
    i_halt = 1'b1;
    tick();
    wait_drain();
    check("halt_noreq", {31'b0, o_mem_req}, 32'd0);

    // Fill with ready low: four queued, no fifth request; drain, resume at 16
    i_ready       = 1'b0;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0;
    i_halt        = 1'b0;
    tick();
    i_redirect = 1'b0;
    check("redir_req",   {31'b0, o_mem_req}, 32'd1);
    check("redir_addr",  o_mem_addr, 32'h0);
    check("redir_valid", {31'b0, o_valid}, 32'd0);
    repeat (20) tick();
    check("full_noreq", {31'b0, o_mem_req}, 32'd0);
    check("full_valid", {31'b0, o_valid}, 32'd1);
    check("full_head",  o_pc, 32'h0);
    expect_insn(32'h0);
    expect_insn(32'h4);
    expect_insn(32'h8);
    expect_insn(32'hC);
    expect_insn(32'h10);
    i_ready = 1'b1;
    wait_req(6);
    check("resume_addr", o_mem_addr, 32'h10);
    i_halt = 1'b1;
    tick();
    wait_drain();

    // Redirect while WAITing on 0x14: that response is dropped
    mem_lat = 3;
    i_halt  = 1'b0;
    wait_req(4);
    check("pre_redir_addr", o_mem_addr, 32'h14);
    tick();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h100;
    tick();
    i_redirect = 1'b0;
    check("drop_noreq", {31'b0, o_mem_req}, 32'd0);
    expect_insn(32'h100);
    wait_req(8);
    check("post_drop_addr", o_mem_addr, 32'h100);
    i_halt = 1'b1;
    tick();
    wait_drain();

    // Redirect in the cycle the response arrives: response discarded
    mem_lat = 1;
    i_halt  = 1'b0;
    wait_req(4);
    check("addr104", o_mem_addr, 32'h104);
    tick();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h200;
    tick();
    i_redirect = 1'b0;
    check("same_cyc_req",   {31'b0, o_mem_req}, 32'd1);
    check("same_cyc_addr",  o_mem_addr, 32'h200);
    check("same_cyc_valid", {31'b0, o_valid}, 32'd0);
    expect_insn(32'h200);
    i_halt = 1'b1;
    tick();
    wait_drain();

    // Halt during WAIT: response still enqueued, fetch resumes sequentially
    mem_lat = 2;
    i_halt  = 1'b0;
    wait_req(4);
    check("addr204", o_mem_addr, 32'h204);
    tick();
    i_halt = 1'b1;
    expect_insn(32'h204);
    for (int i = 0; i < 6; i++) begin
      check("halt_wait_noreq", {31'b0, o_mem_req}, 32'd0);
      tick();
    end
    wait_drain();
    i_halt = 1'b0;
    wait_req(4);
    check("halt_resume_addr", o_mem_addr, 32'h208);
    expect_insn(32'h208);
    i_halt = 1'b1;
    tick();
    wait_drain();

    // Address wrap
    mem_lat       = 1;
    i_halt        = 1'b0;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    i_redirect = 1'b0;
    check("wrap_first", o_mem_addr, 32'hFFFF_FFFC);
    expect_insn(32'hFFFF_FFFC);
    expect_insn(32'h0);
    tick();
    wait_req(4);
    check("wrap_next", o_mem_addr, 32'h0);
    i_halt = 1'b1;
    tick();
    wait_drain();

    // Misaligned redirect
    i_halt = 1'b0;
`ifdef IFQ_MISALIGN_TRAP_EN
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h102;
    tick();
    i_redirect = 1'b0;
    check("mis_fault", {31'b0, o_fault}, 32'd1);
    check("mis_noreq", {31'b0, o_mem_req}, 32'd0);
    repeat (3) tick();
    check("mis_sticky", {31'b0, o_fault}, 32'd1);
    check("mis_still_noreq", {31'b0, o_mem_req}, 32'd0);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h200;
    tick();
    i_redirect = 1'b0;
    check("fix_fault", {31'b0, o_fault}, 32'd0);
    check("fix_req",   {31'b0, o_mem_req}, 32'd1);
    check("fix_addr",  o_mem_addr, 32'h200);
    expect_insn(32'h200);
`else
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h302;
    tick();
    i_redirect = 1'b0;
    check("mis_fault", {31'b0, o_fault}, 32'd0);
    check("mis_req",   {31'b0, o_mem_req}, 32'd1);
    check("mis_addr",  o_mem_addr, 32'h300);
    expect_insn(32'h300);
`endif
    i_halt = 1'b1;
    tick();
    wait_drain();

    // Reset in the middle of a fetch
    mem_lat = 3;
    i_halt  = 1'b0;
    wait_req(4);
    tick();
    i_reset = 1'b1;
    repeat (3) tick();
    check("mid_rst_req",   {31'b0, o_mem_req}, 32'd0);
    check("mid_rst_valid", {31'b0, o_valid},   32'd0);
    check("mid_rst_pc",    o_pc, 32'h0);
    expect_insn(32'h0);
    i_reset = 1'b0;
    wait_req(4);
    check("mid_rst_addr", o_mem_addr, 32'h0);
    i_halt = 1'b1;
    tick();
    wait_drain();
    repeat (5) tick();
    check("final_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
